// File: rtl/alut_req_sched6_pkg.sv
// Shared encodings for the ALUT request scheduler: FSM states and the
// register-bank command that triggers an age check.
package alut_req_sched6_pkg;

  typedef enum logic [1:0] {
    ST_IDLE6 = 2'd0,
    ST_ADDR6 = 2'd1,
    ST_AGE6  = 2'd2
  } sched_state_e;

  localparam logic [1:0] CMD_INV_AGED6 = 2'b01;

endpackage

// File: rtl/alut_rr_arb6.sv
// Combinational round-robin pick: the first requester after i_ptr (with wrap)
// wins; returns it one-hot and as an index.
module alut_rr_arb6 #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [1:0]           i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [1:0]           o_idx,
  output logic                 o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % NUM_PORTS]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + i) % NUM_PORTS] = 1'b1;
        o_idx = 2'((int'(i_ptr) + i) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/alut_req_sched6.sv
// Shares the ALUT address checker between frame ports (round-robin) and
// interleaves age checks from a prescaler or the invalidate-aged command.
module alut_req_sched6
  import alut_req_sched6_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 48
) (
  input  logic                        pclk6,
  input  logic                        n_p_reset6,
  input  logic [NUM_PORTS-1:0]        req6,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_d_addr6,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_s_addr6,
  output logic [NUM_PORTS-1:0]        grant6,
  output logic [NUM_PORTS-1:0]        rsp_valid6,
  output logic [4:0]                  rsp_d_port6,
  output logic                        chk_start6,
  output logic [ADDR_W-1:0]           chk_d_addr6,
  output logic [ADDR_W-1:0]           chk_s_addr6,
  output logic [1:0]                  chk_s_port6,
  input  logic                        chk_done6,
  input  logic [4:0]                  chk_d_port6,
  input  logic [7:0]                  div_clk6,
  input  logic [1:0]                  command6,
  output logic                        age_start6,
  input  logic                        age_done6,
  output logic                        busy6,
  output logic [1:0]                  dbg_state6
);

  sched_state_e         r_state;
  logic [1:0]           r_ptr;
  logic                 r_age_pend;
  logic [7:0]           r_cnt;

  logic [NUM_PORTS-1:0] w_gnt;
  logic [1:0]           w_idx;
  logic                 w_any;
  logic                 w_tick;
  logic                 w_cmd;
  logic                 w_take_age;

  alut_rr_arb6 #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .i_req (req6),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // >= rather than == so lowering div_clk6 below the count wraps at once.
  assign w_tick     = (div_clk6 != 8'd0) && (r_cnt >= div_clk6 - 8'd1);
  assign w_cmd      = (command6 == CMD_INV_AGED6);
  assign w_take_age = (r_state == ST_IDLE6) && r_age_pend;
  assign dbg_state6 = r_state;

  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      r_cnt      <= 8'd0;
      r_age_pend <= 1'b0;
    end else begin
      if (div_clk6 == 8'd0 || w_tick) r_cnt <= 8'd0;
      else                            r_cnt <= r_cnt + 8'd1;
      // Single flag: coincident or repeated triggers collapse to one check.
      r_age_pend <= (r_age_pend && !w_take_age) || w_tick || w_cmd;
    end
  end

  always_ff @(posedge pclk6 or negedge n_p_reset6) begin
    if (!n_p_reset6) begin
      r_state     <= ST_IDLE6;
      r_ptr       <= 2'(NUM_PORTS - 1);
      grant6      <= '0;
      rsp_valid6  <= '0;
      rsp_d_port6 <= 5'd0;
      chk_start6  <= 1'b0;
      chk_d_addr6 <= '0;
      chk_s_addr6 <= '0;
      chk_s_port6 <= 2'd0;
      age_start6  <= 1'b0;
      busy6       <= 1'b0;
    end else begin
      chk_start6 <= 1'b0;
      age_start6 <= 1'b0;
      rsp_valid6 <= '0;
      case (r_state)
        ST_IDLE6: begin
          if (r_age_pend) begin
            r_state    <= ST_AGE6;
            age_start6 <= 1'b1;
            busy6      <= 1'b1;
          end else if (w_any) begin
            r_state     <= ST_ADDR6;
            grant6      <= w_gnt;
            chk_start6  <= 1'b1;
            chk_d_addr6 <= req_d_addr6[int'(w_idx)*ADDR_W +: ADDR_W];
            chk_s_addr6 <= req_s_addr6[int'(w_idx)*ADDR_W +: ADDR_W];
            chk_s_port6 <= w_idx;
            r_ptr       <= w_idx;
            busy6       <= 1'b1;
          end
        end
        ST_ADDR6: begin
          if (chk_done6) begin
            r_state     <= ST_IDLE6;
            rsp_valid6  <= grant6;
            rsp_d_port6 <= chk_d_port6;
            grant6      <= '0;
            busy6       <= 1'b0;
          end
        end
        ST_AGE6: begin
          if (age_done6) begin
            r_state <= ST_IDLE6;
            busy6   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE6;
          busy6   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alut_req_sched6.sv
// Bench for alut_req_sched6: acts as frame ports, address checker and age
// checker, and predicts grants from a simple round-robin reference.
module tb_alut_req_sched6;
  localparam int NP = 4;
  localparam int AW = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req;
  logic [AW-1:0]     d_addr [NP];
  logic [AW-1:0]     s_addr [NP];
  logic [NP*AW-1:0]  d_bus, s_bus;
  logic [NP-1:0]     grant6, rsp_valid6;
  logic [4:0]        rsp_d_port6, chk_d_port6;
  logic              chk_start6, chk_done6, age_start6, age_done6, busy6;
  logic [AW-1:0]     chk_d_addr6, chk_s_addr6;
  logic [1:0]        chk_s_port6, command6, dbg_state6;
  logic [7:0]        div_clk6;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl_ptr;
  int age_max = 7;
  int age_dn  = -1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign d_bus[g*AW +: AW] = d_addr[g];
    assign s_bus[g*AW +: AW] = s_addr[g];
  end

  alut_req_sched6 #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
    .pclk6(clk), .n_p_reset6(rst_n), .req6(req),
    .req_d_addr6(d_bus), .req_s_addr6(s_bus),
    .grant6(grant6), .rsp_valid6(rsp_valid6), .rsp_d_port6(rsp_d_port6),
    .chk_start6(chk_start6), .chk_d_addr6(chk_d_addr6), .chk_s_addr6(chk_s_addr6),
    .chk_s_port6(chk_s_port6), .chk_done6(chk_done6), .chk_d_port6(chk_d_port6),
    .div_clk6(div_clk6), .command6(command6), .age_start6(age_start6),
    .age_done6(age_done6), .busy6(busy6), .dbg_state6(dbg_state6)
  );

  // Age checker model: answers each age_start6 after 1..age_max+1 cycles.
  initial begin
    age_done6 = 1'b0;
    forever begin
      @(negedge clk);
      age_done6 = 1'b0;
      if (!rst_n) age_dn = -1;
      else if (age_dn == 0) begin age_done6 = 1'b1; age_dn = -1; end
      else if (age_dn > 0) age_dn--;
      if (age_start6) age_dn = $urandom_range(0, age_max);
    end
  end

  // Round-robin reference: first requester after the last winner.
  function automatic int mdl_pick(input logic [NP-1:0] m);
    for (int k = 1; k <= NP; k++) begin
      if (m[(mdl_ptr + k) % NP]) return (mdl_ptr + k) % NP;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] onehot(input int i);
    logic [NP-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic randomize_addrs();
    logic [63:0] t;
    for (int i = 0; i < NP; i++) begin
      t = {$urandom(), $urandom()}; d_addr[i] = t[AW-1:0];
      t = {$urandom(), $urandom()}; s_addr[i] = t[AW-1:0];
    end
  endtask

  task automatic wait_chk_start(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (chk_start6) begin ok = 1'b1; break; end
    end
  endtask

  // One full lookup against the reference; leaves req at mask on return.
  task automatic run_lookup(input logic [NP-1:0] mask, input logic [4:0] dp, input string tag);
    int e;
    bit ok;
    e = mdl_pick(mask);
    req = mask;
    wait_chk_start(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL %s start: no chk_start6 within bound", tag);
      return;
    end
    n_tests++;
    if (grant6 !== onehot(e) || chk_s_port6 !== 2'(e) || busy6 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s grant: got grant=%b port=%0d busy=%b, want grant=%b port=%0d busy=1",
               tag, grant6, chk_s_port6, busy6, onehot(e), e);
    end
    n_tests++;
    if (chk_d_addr6 !== d_addr[e] || chk_s_addr6 !== s_addr[e]) begin
      n_fail++;
      $display("FAIL %s addr: got d=%h s=%h, want d=%h s=%h", tag, chk_d_addr6, chk_s_addr6, d_addr[e], s_addr[e]);
    end
    mdl_ptr = e;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    chk_d_port6 = dp; chk_done6 = 1'b1;
    @(negedge clk);
    chk_done6 = 1'b0;
    n_tests++;
    if (rsp_valid6 !== onehot(e) || rsp_d_port6 !== dp || grant6 !== '0) begin
      n_fail++;
      $display("FAIL %s rsp: got rsp_valid=%b d_port=%h grant=%b, want rsp_valid=%b d_port=%h grant=0",
               tag, rsp_valid6, rsp_d_port6, grant6, onehot(e), dp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; chk_done6 = 1'b0; chk_d_port6 = '0;
    div_clk6 = '0; command6 = '0; mdl_ptr = NP - 1;
    randomize_addrs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (grant6 !== '0 || rsp_valid6 !== '0 || rsp_d_port6 !== '0 || chk_start6 !== 1'b0 ||
        age_start6 !== 1'b0 || busy6 !== 1'b0 || dbg_state6 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset ctrl: grant=%b rsp=%b dport=%h start=%b age=%b busy=%b st=%0d, want all 0",
               grant6, rsp_valid6, rsp_d_port6, chk_start6, age_start6, busy6, dbg_state6);
    end
    n_tests++;
    if (chk_d_addr6 !== '0 || chk_s_addr6 !== '0 || chk_s_port6 !== '0) begin
      n_fail++;
      $display("FAIL reset addr: d=%h s=%h port=%0d, want 0", chk_d_addr6, chk_s_addr6, chk_s_port6);
    end
  endtask

  task automatic test_rr_all();
    for (int k = 0; k < 5; k++) run_lookup(4'b1111, 5'h13, $sformatf("rr%0d", k));
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    d_addr[2] = 48'h0011_2233_4455;
    req = 4'b0100;
    @(negedge clk);
    n_tests++;
    if (chk_start6 !== 1'b1 || grant6 !== 4'b0100 || chk_s_port6 !== 2'd2 || chk_d_addr6 !== 48'h0011_2233_4455) begin
      n_fail++;
      $display("FAIL single grant: start=%b grant=%b port=%0d d=%h, want 1 0100 2 001122334455",
               chk_start6, grant6, chk_s_port6, chk_d_addr6);
    end
    mdl_ptr = 2;
    repeat (2) @(negedge clk);
    chk_d_port6 = 5'h05; chk_done6 = 1'b1;
    @(negedge clk);
    chk_done6 = 1'b0; req = '0;
    n_tests++;
    if (rsp_valid6 !== 4'b0100 || rsp_d_port6 !== 5'h05 || busy6 !== 1'b0) begin
      n_fail++;
      $display("FAIL single rsp: rsp=%b dport=%h busy=%b, want 0100 05 0", rsp_valid6, rsp_d_port6, busy6);
    end
    @(negedge clk);
  endtask

  task automatic test_spurious_done();
    chk_d_port6 = 5'h1f; chk_done6 = 1'b1;
    @(negedge clk);
    chk_done6 = 1'b0;
    n_tests++;
    if (rsp_valid6 !== '0 || busy6 !== 1'b0 || rsp_d_port6 !== 5'h05) begin
      n_fail++;
      $display("FAIL spurious: rsp=%b busy=%b dport=%h, want 0 0 05", rsp_valid6, busy6, rsp_d_port6);
    end
  endtask

  task automatic test_random();
    logic [NP-1:0] m;
    for (int k = 0; k < 12; k++) begin
      randomize_addrs();
      m = NP'($urandom_range(1, (1 << NP) - 1));
      run_lookup(m, 5'($urandom()), $sformatf("rand%0d", k));
      req = '0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_prescaler();
    int last, pulses, bad;
    last = -1; pulses = 0; bad = 0;
    div_clk6 = 8'd10;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (age_start6) begin
        if (last >= 0 && c - last != 10) bad++;
        last = c; pulses++;
      end
    end
    n_tests++;
    if (bad != 0 || pulses < 7) begin
      n_fail++;
      $display("FAIL prescale period: pulses=%0d off_period=%0d, want >=7 pulses 10 apart", pulses, bad);
    end
    div_clk6 = 8'd0;
    repeat (20) @(negedge clk);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (age_start6) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL prescale off: pulses=%0d, want 0", pulses);
    end
  endtask

  task automatic test_cmd_during_addr();
    int e;
    bit ok, got_age, got_chk;
    run_lookup(4'b0011, 5'h0a, "cmd_first");
    // run_lookup returned after the done; redo with a command in flight
    req = '0;
    repeat (2) @(negedge clk);
    e = mdl_pick(4'b0011);
    req = 4'b0011;
    wait_chk_start(ok);
    mdl_ptr = e;
    command6 = 2'b01;
    @(negedge clk);
    command6 = 2'b00;
    @(negedge clk);
    chk_d_port6 = 5'h11; chk_done6 = 1'b1;
    @(negedge clk);
    chk_done6 = 1'b0;
    got_age = 1'b0; got_chk = 1'b0;
    for (int c = 0; c < 40 && !got_age && !got_chk; c++) begin
      @(negedge clk);
      got_age = age_start6;
      got_chk = chk_start6;
    end
    n_tests++;
    if (!ok || got_age !== 1'b1 || got_chk !== 1'b0) begin
      n_fail++;
      $display("FAIL cmd priority: first_start ok=%b age=%b chk=%b, want age before address", ok, got_age, got_chk);
    end
    run_lookup(4'b0011, 5'h12, "cmd_after_age");
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_merge();
    int pulses;
    div_clk6 = 8'd0;
    repeat (5) @(negedge clk);
    div_clk6 = 8'd4;
    repeat (3) @(negedge clk);
    command6 = 2'b01;
    @(negedge clk);
    command6 = 2'b00; div_clk6 = 8'd0;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (age_start6) pulses++;
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL merge: age_start pulses=%0d, want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    req = 4'b1111;
    wait_chk_start(ok);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (!ok || grant6 !== '0 || busy6 !== 1'b0 || chk_start6 !== 1'b0 || chk_s_port6 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset mid: started=%b grant=%b busy=%b start=%b port=%0d, want 1 0 0 0 0",
               ok, grant6, busy6, chk_start6, chk_s_port6);
    end
    mdl_ptr = NP - 1;
    @(negedge clk);
    rst_n = 1'b1;
    run_lookup(4'b1111, 5'h07, "after_reset");
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_rr_all();
    test_single();
    test_spurious_done();
    test_random();
    test_prescaler();
    test_cmd_during_addr();
    test_merge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_tests++; n_fail++;
    $display("FAIL global timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
